// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: MDUOp encodings and default latencies.
// The hazard unit imports the same encodings.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // Two's-complement magnitude when sgn is set; the most negative value maps to itself as unsigned.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational MDU datapath: produces the {HI, LO} result of mult/multu/div/divu
// plus a divide-by-zero flag; other opcodes yield zero.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               is_sdiv;
  logic        [31:0] ua, ub, ub_safe, uq, ur;

  always_comb begin
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'd0, a} * {32'd0, b};
    is_sdiv = (op == MDU_DIV);
    div0    = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    ua      = mag(a, is_sdiv);
    ub      = mag(b, is_sdiv);
    ub_safe = div0 ? 32'd1 : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    hi_n    = 32'd0;
    lo_n    = 32'd0;
    case (op)
      MDU_MULT:  {hi_n, lo_n} = prod_s;
      MDU_MULTU: {hi_n, lo_n} = prod_u;
      MDU_DIV: begin
        lo_n = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
        hi_n = a[31] ? (~ur + 32'd1) : ur;
      end
      MDU_DIVU: begin
        lo_n = uq;
        hi_n = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, holds busy for a fixed latency
// after each mult/div start and commits the shadow result when the counter expires.
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  output logic        E_start,
  output logic        E_busy,
  output logic        E_MDU_stall_src,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDU_out
);

  localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hin_q, hin_d, lon_q, lon_d;
  logic             div0_q, div0_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] hi_n, lo_n;
  logic        div0_n, is_md, is_div;

  mdu_arith u_arith (
    .op   (E_MDUOp),
    .a    (E_A),
    .b    (E_B),
    .hi_n (hi_n),
    .lo_n (lo_n),
    .div0 (div0_n)
  );

  always_comb begin
    is_md  = (E_MDUOp >= MDU_MULT) && (E_MDUOp <= MDU_DIVU);
    is_div = (E_MDUOp == MDU_DIV) || (E_MDUOp == MDU_DIVU);
    E_start = is_md && !Req && !busy_q;

    hi_d   = hi_q;
    lo_d   = lo_q;
    hin_d  = hin_q;
    lon_d  = lon_q;
    div0_d = div0_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;

    if (E_start) begin
      hin_d  = hi_n;
      lon_d  = lo_n;
      div0_d = div0_n;
      cnt_d  = is_div ? DIV_LD : MULT_LD;
      busy_d = 1'b1;
    end else if (cnt_q != '0) begin
      // A running operation belongs to an older instruction, so Req does not stop it.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (!div0_q) begin
          hi_d = hin_q;
          lo_d = lon_q;
        end
      end
    end else if (!Req && !busy_q) begin
      if (E_MDUOp == MDU_MTHI) hi_d = E_A;
      if (E_MDUOp == MDU_MTLO) lo_d = E_A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      hin_q  <= '0;
      lon_q  <= '0;
      div0_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hin_q  <= hin_d;
      lon_q  <= lon_d;
      div0_q <= div0_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    E_busy          = busy_q;
    E_MDU_stall_src = E_start | busy_q;
    HI              = hi_q;
    LO              = lo_q;
    E_MDU_out       = 32'd0;
    if (E_MDUOp == MDU_MFHI) E_MDU_out = hi_q;
    if (E_MDUOp == MDU_MFLO) E_MDU_out = lo_q;
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed scenarios followed by random
// operations compared against an arithmetic reference model of HI/LO and latency.
module tb_e_mdu_ctrl;

  localparam int LAT_MULT = 5;
  localparam int LAT_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        req;
  logic        E_start, E_busy, E_MDU_stall_src;
  logic [31:0] HI, LO, E_MDU_out;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu_ctrl #(.MULT_CYC(LAT_MULT), .DIV_CYC(LAT_DIV)) dut (
    .clk             (clk),
    .reset           (reset),
    .E_MDUOp         (op),
    .E_A             (a),
    .E_B             (b),
    .Req             (req),
    .E_start         (E_start),
    .E_busy          (E_busy),
    .E_MDU_stall_src (E_MDU_stall_src),
    .HI              (HI),
    .LO              (LO),
    .E_MDU_out       (E_MDU_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {div0, HI, LO} from plain 64-bit integer arithmetic.
  function automatic logic [64:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      4'd1: begin sp = sx * sy; return {1'b0, sp[63:0]}; end
      4'd2: begin up = ux * uy; return {1'b0, up[63:0]}; end
      4'd3: begin
        if (y == 32'd0) return {1'b1, 64'd0};
        sq = sx / sy;
        sr = sx % sy;
        return {1'b0, sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (y == 32'd0) return {1'b1, 64'd0};
        uq = ux / uy;
        ur = ux % uy;
        return {1'b0, ur[31:0], uq[31:0]};
      end
      default: return 65'd0;
    endcase
  endfunction

  // mode: 0 plain, 1 Req mid-operation, 2 mthi during busy, 3 mult during busy
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int mode);
    logic [64:0] r;
    int n, lat;
    r   = model(o, x, y);
    lat = (o == 4'd1 || o == 4'd2) ? LAT_MULT : LAT_DIV;
    op = o; a = x; b = y; req = 1'b0;
    #1;
    chk("start", E_start, 1);
    chk("stall_src_start", E_MDU_stall_src, 1);
    step();
    op = 4'd0;
    n = 0;
    while (E_busy === 1'b1 && n < 40) begin
      n++;
      if (n == 1) begin
        op = 4'd7; #1; chk("mfhi_busy_old", E_MDU_out, m_hi);
        op = 4'd8; #1; chk("mflo_busy_old", E_MDU_out, m_lo);
        op = 4'd0;
      end
      if (n == 2) begin
        case (mode)
          1: req = 1'b1;
          2: begin op = 4'd5; a = 32'h55; end
          3: begin op = 4'd1; a = $urandom; b = $urandom; end
          default: ;
        endcase
        #1;
        chk("no_start_busy", E_start, 0);
        chk("stall_src_busy", E_MDU_stall_src, 1);
      end
      step();
      op = 4'd0;
      req = 1'b0;
    end
    chk("busy_len", n, lat);
    if (!r[64]) {m_hi, m_lo} = r[63:0];
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    chk("busy_done", E_busy, 0);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    op = o; a = v; req = 1'b0;
    #1;
    chk("mt_nostart", E_start, 0);
    step();
    op = 4'd0;
    if (o == 4'd5) m_hi = v;
    else m_lo = v;
    chk("mt_hi", HI, m_hi);
    chk("mt_lo", LO, m_lo);
  endtask

  task automatic idle_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic r);
    op = o; a = x; b = y; req = r;
    #1;
    chk("idle_nostart", E_start, 0);
    chk("idle_out", E_MDU_out, (o == 4'd7) ? m_hi : ((o == 4'd8) ? m_lo : 32'd0));
    step();
    op = 4'd0;
    req = 1'b0;
    chk("idle_busy", E_busy, 0);
    chk("idle_hi", HI, m_hi);
    chk("idle_lo", LO, m_lo);
  endtask

  initial begin
    logic [3:0]  o;
    logic [31:0] x, y;
    logic        r;

    reset = 1'b0; op = 4'd0; a = '0; b = '0; req = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", E_busy, 0);
    op = 4'd7; #1;
    chk("rst_out", E_MDU_out, 0);
    op = 4'd0;
    reset = 1'b1;
    step();

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 0);
    chk("mult_hi_k", HI, 32'hFFFFFFFF);
    chk("mult_lo_k", LO, 32'hFFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 0);
    chk("multu_hi_k", HI, 32'h00000002);
    chk("multu_lo_k", LO, 32'hFFFFFFFA);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_lo_k", LO, 32'hFFFFFFFD);
    chk("div_hi_k", HI, 32'hFFFFFFFF);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("divovf_lo_k", LO, 32'h80000000);
    chk("divovf_hi_k", HI, 32'h0);

    mt(4'd5, 32'h11);
    mt(4'd6, 32'h22);
    run_op(4'd4, 32'h1234, 32'd0, 0);
    chk("div0_hi_k", HI, 32'h11);
    chk("div0_lo_k", LO, 32'h22);

    idle_op(4'd1, 32'd5, 32'd7, 1'b1);
    idle_op(4'd5, 32'hDEAD, 32'd0, 1'b1);
    run_op(4'd3, 32'd100, 32'd7, 1);
    run_op(4'd1, 32'd3, 32'd5, 2);
    chk("mthi_busy_k", HI, 32'h0);
    run_op(4'd1, 32'd6, 32'd7, 3);
    chk("mult_busy_lo_k", LO, 32'd42);

    // Asynchronous reset in cycle 3 of a mult.
    op = 4'd1; a = 32'h12345; b = 32'h6789; req = 1'b0;
    step();
    op = 4'd0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", E_busy, 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    step();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (8) step();
    chk("arst_busy_after", E_busy, 0);
    chk("arst_hi_after", HI, 0);
    chk("arst_lo_after", LO, 0);

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 11));
      x = $urandom;
      y = $urandom;
      if ($urandom % 5 == 0) y = 32'd0;
      else if ($urandom % 5 == 0) y = 32'hFFFFFFFF;
      if ($urandom % 6 == 0) x = 32'h80000000;
      r = ($urandom % 4 == 0);
      if (o >= 4'd1 && o <= 4'd4 && !r) run_op(o, x, y, 0);
      else if ((o == 4'd5 || o == 4'd6) && !r) mt(o, x);
      else idle_op(o, x, y, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
